// File: rtl/core_pkg.sv
// core_pkg
// Types and widths shared by the fetch unit, the IF/ID instruction queue and
// the decode unit. The pair of a PC and the instruction word fetched from it
// is carried between these stages as a single fetch_pkt_t.
//   PC_W        : program counter width
//   INSTR_W     : instruction word width
//   fetch_pkt_t : {pc, instr} fetched pair

package core_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

endpackage : core_pkg

// File: rtl/if_id_queue.sv
// if_id_queue
// Small flop-based FIFO between fetch and decode. It holds fetched
// {pc, instr} pairs so that a decode stall does not lose them. A flush
// discards every entry in one cycle on a branch/jump redirect.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   flush      : discard all entries; a same-cycle enqueue is dropped
//   in_valid   : fetch presents {in_pc, in_instr}
//   in_ready   : queue has room (registered state only)
//   in_pc      : PC of the fetched instruction
//   in_instr   : fetched instruction word
//   out_valid  : head entry available to decode
//   out_ready  : decode consumes the head this cycle
//   out_pc     : head PC, zero while empty
//   out_instr  : head instruction, zero while empty
//   count      : current occupancy, 0..DEPTH

module if_id_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = core_pkg::PC_W,
  parameter int INSTR_W = core_pkg::INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  import core_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_pkt_t    storage [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          enq;
  logic          deq;

  // Handshake status comes from the registered occupancy only, so a
  // dequeue from a full queue does not open a slot until the next cycle.
  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  // The head is masked while empty so stale storage never leaks to decode.
  assign out_pc    = out_valid ? storage[rd_ptr].pc    : '0;
  assign out_instr = out_valid ? storage[rd_ptr].instr : '0;

  // Pointer and occupancy update. Reset and flush both empty the queue,
  // and either one suppresses any enqueue/dequeue seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; its contents are only observable
  // through the masked head, so only the write enable needs gating.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq) begin
      storage[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue
// Drives directed scenarios and a long random run into if_id_queue and
// compares every cycle against a queue-based model of the FIFO.

module tb_if_id_queue;

  import core_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  bit         chk_en = 1'b0;
  fetch_pkt_t mdl_q [$];
  bit         last_acc  = 1'b0;
  bit         last_drop = 1'b0;
  bit         prev_pending = 1'b0;
  logic [63:0] prev_pc;
  logic [31:0] prev_instr;
  bit         seen_flushed_pc = 1'b0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  // One comparison; records a failure with actual and required values.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sets all inputs just after a falling edge and advances one full cycle.
  task automatic applyStimulus(input bit r, input bit f, input bit v,
                               input logic [63:0] pc, input logic [31:0] instr,
                               input bit ordy);
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
    @(negedge clk);
  endtask

  // Reference model: a plain queue. Handshakes are decided from the
  // occupancy before the edge; reset and flush simply empty it.
  always @(posedge clk) begin
    automatic int  n  = mdl_q.size();
    automatic bit  e  = in_valid && (n < DEPTH);
    automatic bit  d  = out_ready && (n != 0);
    if (chk_en && prev_pending && !rst && !flush) begin
      total++;
      if (!(in_valid && in_pc == prev_pc && in_instr == prev_instr)) begin
        bad++;
        $display("[TB] FAIL hold_assumption: got v=%b pc=%h want v=1 pc=%h", in_valid, in_pc, prev_pc);
      end
    end
    if (rst || flush) begin
      mdl_q.delete();
      last_acc = 1'b0;
    end else begin
      if (d) void'(mdl_q.pop_front());
      if (e) mdl_q.push_back('{pc: in_pc, instr: in_instr});
      last_acc = e;
    end
    last_drop    = rst || flush;
    prev_pending = in_valid && !e && !rst && !flush;
    prev_pc      = in_pc;
    prev_instr   = in_instr;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic int          n   = mdl_q.size();
      automatic logic [63:0] epc = (n != 0) ? mdl_q[0].pc : 64'h0;
      automatic logic [31:0] ein = (n != 0) ? mdl_q[0].instr : 32'h0;
      checkOutput("count",     64'(count),     64'(n));
      checkOutput("out_valid", 64'(out_valid), 64'(n != 0));
      checkOutput("in_ready",  64'(in_ready),  64'(n < DEPTH));
      checkOutput("out_pc",    out_pc,         epc);
      checkOutput("out_instr", 64'(out_instr), 64'(ein));
      if (out_valid === 1'b1 && out_pc == 64'h8000_1000) seen_flushed_pc = 1'b1;
    end
  end

  initial begin
    logic [63:0] pend_pc;
    logic [31:0] pend_instr;
    bit          pend;
    int          seq;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset held for two cycles
    applyStimulus(1, 0, 0, 64'h0, 32'h0, 0);
    chk_en = 1'b1;
    applyStimulus(0, 0, 0, 64'h0, 32'h0, 1);
    checkOutput("rst_count",     64'(count),     64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_pc",    out_pc,         64'd0);
    checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
    checkOutput("rst_in_ready",  64'(in_ready),  64'd1);

    // Fill with decode stalled, then drain in order
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 64'h8000_0000 + 64'(4*i), 32'h13 + 32'(i), 0);
    checkOutput("fill_count",    64'(count),    64'd4);
    checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_pc",    out_pc,         64'h8000_0000 + 64'(4*i));
      checkOutput("drain_instr", 64'(out_instr), 64'h13 + 64'(i));
      applyStimulus(0, 0, 0, 64'h0, 32'h0, 1);
    end
    checkOutput("drain_count", 64'(count),     64'd0);
    checkOutput("drain_valid", 64'(out_valid), 64'd0);

    // Streaming through an empty queue wraps the pointers
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 1, 64'h8000_2000 + 64'(4*k), 32'h100 + 32'(k), 1);
      checkOutput("stream_count", 64'(count), 64'd1);
      checkOutput("stream_pc",    out_pc,     64'h8000_2000 + 64'(4*k));
    end
    applyStimulus(0, 0, 0, 64'h0, 32'h0, 1);
    checkOutput("stream_end_count", 64'(count), 64'd0);

    // Flush with a simultaneous enqueue
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1, 64'h8000_3000 + 64'(4*i), 32'h200 + 32'(i), 0);
    checkOutput("pre_flush_count", 64'(count), 64'd3);
    applyStimulus(0, 1, 1, 64'h8000_1000, 32'hdead, 0);
    checkOutput("flush_count",    64'(count),     64'd0);
    checkOutput("flush_valid",    64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready),  64'd1);
    applyStimulus(0, 0, 0, 64'h0, 32'h0, 1);
    applyStimulus(0, 0, 0, 64'h0, 32'h0, 1);
    checkOutput("flushed_pc_seen", 64'(seen_flushed_pc), 64'd0);

    // Full queue with a dequeue: no enqueue that cycle
    for (int i = 0; i < 4; i++)
      applyStimulus(0, 0, 1, 64'h8000_4000 + 64'(4*i), 32'h300 + 32'(i), 0);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(0, 0, 1, 64'h8000_5000, 32'h55, 1);
    checkOutput("fulldeq_count",    64'(count),    64'd3);
    checkOutput("fulldeq_in_ready", 64'(in_ready), 64'd1);
    checkOutput("fulldeq_head",     out_pc,        64'h8000_4004);
    applyStimulus(0, 0, 1, 64'h8000_5000, 32'h55, 0);
    checkOutput("late_enq_count", 64'(count), 64'd4);
    applyStimulus(0, 1, 0, 64'h0, 32'h0, 0);

    // Random traffic with occasional flush and reset
    pend = 1'b0;
    pend_pc = '0;
    pend_instr = '0;
    seq = 0;
    for (int i = 0; i < 10000; i++) begin
      automatic bit r_rst   = ($urandom_range(0, 499) == 0);
      automatic bit r_flush = ($urandom_range(0, 49) == 0);
      if (pend && (last_acc || last_drop)) pend = 1'b0;
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend       = 1'b1;
        pend_pc    = 64'h9000_0000 + 64'(4*seq);
        pend_instr = $urandom;
        seq++;
      end
      applyStimulus(r_rst, r_flush, pend, pend_pc, pend_instr, 1'($urandom_range(0, 1)));
    end
    applyStimulus(0, 0, 0, 64'h0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage (PC register + IFU) and the decode stage. Buffers fetched {PC, instruction} pairs in a small synchronous FIFO with valid/ready handshakes on both sides, so that a decode stall does not lose fetched instructions. It supports a single-cycle flush for branch/jump redirects. Single clock domain; all state is reset synchronously.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 64, PC width
- INSTR_W, 32, instruction width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all entries (redirect)
- in_valid  in  1  IFU presents a fetched instruction
- in_ready  out  1  queue accepts this cycle
- in_pc  in  PC_W  PC of fetched instruction
- in_instr  in  INSTR_W  fetched instruction
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  PC_W  head PC
- out_instr  out  INSTR_W  head instruction
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Enqueue fires when in_valid && in_ready; dequeue fires when out_valid && out_ready.
- in_ready = (count < DEPTH). It depends on registered state only, with no combinational path from out_ready. When full, a simultaneous dequeue does not open a slot that same cycle.
- out_valid = (count != 0). out_pc/out_instr = storage[rd_ptr] when out_valid, else all-zero.
- State: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping mod DEPTH, plus count.
- Enqueue only: write storage[wr_ptr], wr_ptr+1, count+1.
- Dequeue only: rd_ptr+1, count−1.
- Enqueue and dequeue together (possible only when 0<count<DEPTH): both pointers advance and count is unchanged.
- Priority per cycle: rst > flush > enqueue/dequeue.
  - flush: wr_ptr, rd_ptr and count all go to 0. A same-cycle enqueue is dropped and a same-cycle dequeue has no additional effect.
- in_valid must stay asserted with stable in_pc/in_instr until accepted. The queue does not enforce this, and the bench checks it as an assumption.
- No bypass: an entry enqueued into an empty queue is not visible on out_* in the same cycle.

## Timing
- Reset values: count=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1. Storage contents are don't-care and never visible, because out_* is masked while empty.
- Enqueue-to-output latency is 1 cycle: a write at edge t is presented on out_* after edge t and can be consumed in cycle t+1.
- Flush is asserted in cycle t. After edge t: out_valid=0, count=0, in_ready=1.
- rst mid-stream behaves like flush and additionally zeroes outputs. It takes effect at the next edge.
- Full boundary: count==DEPTH means in_ready=0. One dequeue restores in_ready=1 the following cycle.
- Empty boundary: count==0 means out_valid=0, and out_ready is ignored.
- Pointer wrap: after DEPTH enqueues, wr_ptr returns to 0. Order is preserved across the wrap.

## Structure
- Shared package (core_pkg): PC_W=64, INSTR_W=32, and the typedef fetch_pkt_t {pc, instr}. IFU, this queue and IDU all use fetch_pkt_t.
- Storage is an array of fetch_pkt_t in flops, not an SRAM macro.
- One module. The pointer/count logic is not split out; a generic FIFO is unnecessary at this size.

## Test plan
- Reset: hold rst 2 cycles → count=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1.
- Fill/drain: out_ready=0, enqueue PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000C with instrs 0x00000013+i.
  - After the 4th: count=4, in_ready=0.
  - Then out_ready=1 → same four pairs come out in order, and count reaches 0.
- Streaming: in_valid=1 and out_ready=1 continuously for 10 cycles → count stays at 1 after the first cycle, one instruction is output per cycle, and wrap-around is exercised with order preserved.
- Flush with simultaneous enqueue: queue holds 3 entries; assert flush together with in_valid (PC 0x80001000) → next cycle count=0, out_valid=0, and PC 0x80001000 is never output.
- Full plus dequeue: count=4 with in_valid=1 and out_ready=1 → that cycle in_ready=0, so there is no enqueue; next cycle count=3 and in_ready=1.
- Random: valid/ready toggled randomly for 10k cycles against a scoreboard model → no loss, no duplication, order preserved, count matches the model.
